// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and the
// baud divisor helper. Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package uart_pkg;

    // Transmit FSM states. PARITY is only reachable when UART_TX_PARITY_EN is defined.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Clocks per serial bit. Integer divide, so the real baud rate is slightly fast
    // whenever freq is not an exact multiple of baud.
    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// Latency: a pushed word is visible on rd_data the cycle after the push edge.
// Backpressure: full is driven from the registered count; a push while full
// and a pop while empty are ignored.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset (clears pointers/count)
//   push, wr_data  write strobe and data
//   pop            read strobe; rd_data shows the head word whenever !empty
//   full, empty    status from the registered count
//   count          occupancy, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset: stale words are never read because empty gates pop.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_stream.sv
// Byte stream to UART TX serialiser, 8N1 LSB first (8E1 when UART_TX_PARITY_EN
// is defined). Latency: byte accepted into an empty FIFO with the FSM idle ->
// start bit on uart_tx after the following edge. Backpressure: ascii_ready = !full.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset (aborts frame, drops FIFO)
//   ascii_data/valid/ready    byte input, accepted on valid && ready
//   uart_tx                   registered serial output, idle high
//   busy                      FSM not idle or FIFO non-empty
//   fifo_level                FIFO occupancy
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    ascii_data,
    input  logic                          ascii_valid,
    output logic                          ascii_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int             CPB       = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int             CW        = $clog2(CPB);
    localparam logic [CW-1:0]  BAUD_LAST = CW'(CPB - 1);

    tx_state_t      state;
    logic [CW-1:0]  baud_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
`ifdef UART_TX_PARITY_EN
    logic           parity_bit;
`endif

    logic           fifo_full;
    logic           fifo_empty;
    logic [7:0]     fifo_rd_data;
    logic           push;
    logic           pop;
    logic           bit_end;

    assign ascii_ready = !fifo_full;
    assign push        = ascii_valid && ascii_ready;
    assign bit_end     = (baud_cnt == BAUD_LAST);

    // Pop either from IDLE, or in the last stop clock so the next start bit
    // follows the stop bit with no idle gap.
    assign pop = !fifo_empty &&
                 ((state == IDLE) || ((state == STOP) && bit_end));

    assign busy = (state != IDLE) || (fifo_level != '0);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (ascii_data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_level)
    );

    // uart_tx is loaded with the level of the state being entered, so the
    // line and the state register change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            uart_tx  <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            baud_cnt <= bit_end ? '0 : baud_cnt + CW'(1);

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        state   <= START;
                        uart_tx <= 1'b0;
                        shift   <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^fifo_rd_data;
`endif
                    end
                end

                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        uart_tx <= shift[0];
                        shift   <= {1'b0, shift[7:1]};
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state   <= PARITY;
                            uart_tx <= parity_bit;
`else
                            state   <= STOP;
                            uart_tx <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= shift[0];
                            shift   <= {1'b0, shift[7:1]};
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state   <= STOP;
                        uart_tx <= 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            state   <= START;
                            uart_tx <= 1'b0;
                            shift   <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
                            parity_bit <= ^fifo_rd_data;
`endif
                        end else begin
                            state   <= IDLE;
                            uart_tx <= 1'b1;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed self-checking bench for uart_tx_stream at 10 clocks per bit.
// Inputs are driven and outputs sampled 1 time unit after the rising edge;
// a line decoder samples mid-bit 2 units after the edge.
module tb_uart_tx_stream;

    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ascii_data;
    logic       ascii_valid;
    logic       ascii_ready;
    logic       uart_tx;
    logic       busy;
    logic [4:0] fifo_level;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] rx_q[$];
    int         start_q[$];
    bit         dec_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_stream #(
        .CLK_FREQ   (1_000_000),
        .BAUD_RATE  (100_000),
        .FIFO_DEPTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ascii_data  (ascii_data),
        .ascii_valid (ascii_valid),
        .ascii_ready (ascii_ready),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .fifo_level  (fifo_level)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rx(input string tag, input int n, input int limit);
        int i;
        i = 0;
        while (rx_q.size() < n && i < limit) begin
            tick();
            i++;
        end
        chk(tag, rx_q.size(), n);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int i;
        i = 0;
        while (busy && i < limit) begin
            tick();
            i++;
        end
        chk(tag, busy, 1'b0);
    endtask

    // Push one byte into an idle DUT and compare every clock of the frame
    // against the hand-built bit sequence.
    task automatic send_wave(input logic [7:0] b, input string tag);
        logic [10:0] fr;
        int errs;
        fr       = '1;
        fr[0]    = 1'b0;
        fr[8:1]  = b;
`ifdef UART_TX_PARITY_EN
        fr[9]    = ^b;
`endif
        chk({tag, "_rdy"}, ascii_ready, 1'b1);
        ascii_data  = b;
        ascii_valid = 1'b1;
        tick();
        ascii_valid = 1'b0;
        chk({tag, "_lvl1"}, fifo_level, 5'd1);
        chk({tag, "_pre_idle"}, uart_tx, 1'b1);
        tick();
        chk({tag, "_start_lat"}, uart_tx, 1'b0);
        chk({tag, "_lvl0"}, fifo_level, 5'd0);
        errs = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (uart_tx !== fr[k / CPB] || busy !== 1'b1) errs++;
            tick();
        end
        chk({tag, "_wave_errs"}, errs, 0);
        chk({tag, "_busy_fall"}, busy, 1'b0);
        chk({tag, "_line_idle"}, uart_tx, 1'b1);
    endtask

    // Line decoder: detects the first low sample, then samples mid-bit.
    initial begin : decoder
        logic [7:0] b;
        int st;
        forever begin
            @(posedge clk);
            #2;
            if (dec_en && uart_tx === 1'b0) begin
                st = cyc;
                repeat (CPB / 2 - 1) begin @(posedge clk); #2; end
                chk("rx_start", uart_tx, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) begin @(posedge clk); #2; end
                    b[i] = uart_tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) begin @(posedge clk); #2; end
                chk("rx_parity", uart_tx, ^b);
`endif
                repeat (CPB) begin @(posedge clk); #2; end
                chk("rx_stop", uart_tx, 1'b1);
                rx_q.push_back(b);
                start_q.push_back(st);
            end
        end
    end

    initial begin : main
        logic [7:0] t4_bytes[20];
        int errs;
        int w;
        int idx;
        int lows;
        bit acc;
        bit saw_stall;

        rst         = 1'b1;
        ascii_valid = 1'b0;
        ascii_data  = 8'h00;
        repeat (3) tick();
        chk("rst_tx", uart_tx, 1'b1);
        chk("rst_ready", ascii_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_level", fifo_level, 5'd0);
        rst = 1'b0;
        tick();
        dec_en = 1'b1;

        // 1: single 0x41 frame, exact waveform and busy timing
        send_wave(8'h41, "t1");

        // 2: "12\n" burst, back-to-back frames
        rx_q.delete();
        start_q.delete();
        ascii_valid = 1'b1;
        ascii_data  = 8'h31;
        tick();
        chk("t2_lvl_a", fifo_level, 5'd1);
        ascii_data = 8'h32;
        tick();
        chk("t2_lvl_b", fifo_level, 5'd1);
        ascii_data = 8'h0A;
        tick();
        chk("t2_lvl_c", fifo_level, 5'd2);
        ascii_valid = 1'b0;
        wait_rx("t2_count", 3, 3 * FRAME + 50);
        chk("t2_b0", rx_q[0], 8'h31);
        chk("t2_b1", rx_q[1], 8'h32);
        chk("t2_b2", rx_q[2], 8'h0A);
        chk("t2_gap01", start_q[1] - start_q[0], FRAME);
        chk("t2_gap12", start_q[2] - start_q[1], FRAME);
        wait_idle("t2_idle", 200);

        // 3: fill FIFO while a frame is in flight, 0x10 held until first pop
        rx_q.delete();
        start_q.delete();
        ascii_valid = 1'b1;
        ascii_data  = 8'h55;
        tick();
        for (int v = 0; v < 17; v++) begin
            ascii_data  = 8'(v);
            ascii_valid = 1'b1;
            w = 0;
            while (!ascii_ready && w < 500) begin
                tick();
                w++;
            end
            if (v == 16) begin
                chk("t3_held", (w > 0), 1'b1);
                chk("t3_lvl_release", fifo_level, 5'd15);
            end
            tick();
            if (v == 15) begin
                chk("t3_lvl_full", fifo_level, 5'd16);
                chk("t3_ready_low", ascii_ready, 1'b0);
            end
        end
        ascii_valid = 1'b0;
        wait_rx("t3_count", 18, 18 * FRAME + 100);
        errs = 0;
        if (rx_q[0] !== 8'h55) errs++;
        for (int i = 0; i < 17; i++) begin
            if (rx_q[i + 1] !== 8'(i)) errs++;
        end
        chk("t3_order_errs", errs, 0);
        wait_idle("t3_idle", 200);

        // 4: valid toggling every cycle, garbage on the low cycles
        rx_q.delete();
        start_q.delete();
        for (int i = 0; i < 20; i++) t4_bytes[i] = 8'hC0 + 8'(i);
        idx = 0;
        saw_stall = 1'b0;
        for (int c = 0; c < 4000 && idx < 20; c++) begin
            if (c % 2 == 0) begin
                ascii_valid = 1'b1;
                ascii_data  = t4_bytes[idx];
            end else begin
                ascii_valid = 1'b0;
                ascii_data  = 8'hEE;
            end
            acc = ascii_valid && ascii_ready;
            if (ascii_valid && !ascii_ready) saw_stall = 1'b1;
            tick();
            if (acc) idx++;
        end
        ascii_valid = 1'b0;
        chk("t4_all_accepted", idx, 20);
        chk("t4_saw_stall", saw_stall, 1'b1);
        wait_rx("t4_count", 20, 20 * FRAME + 200);
        wait_idle("t4_idle", 300);
        chk("t4_no_extra", rx_q.size(), 20);
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            if (rx_q[i] !== t4_bytes[i]) errs++;
        end
        chk("t4_order_errs", errs, 0);

        // 5: reset during DATA bit 3 of 0xFF with 4 bytes queued
        dec_en = 1'b0;
        repeat (5) tick();
        ascii_valid = 1'b1;
        ascii_data  = 8'hFF;
        tick();
        for (int i = 0; i < 4; i++) begin
            ascii_data = 8'h11 + 8'(i);
            tick();
        end
        ascii_valid = 1'b0;
        chk("t5_lvl_queued", fifo_level, 5'd4);
        repeat (42) tick();
        chk("t5_mid_bit3", uart_tx, 1'b1);
        rst = 1'b1;
        tick();
        chk("t5_tx", uart_tx, 1'b1);
        chk("t5_level", fifo_level, 5'd0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_ready", ascii_ready, 1'b1);
        rst = 1'b0;
        lows = 0;
        repeat (300) begin
            tick();
            if (uart_tx !== 1'b1) lows++;
        end
        chk("t5_no_frames", lows, 0);
        chk("t5_busy_after", busy, 1'b0);

`ifdef UART_TX_PARITY_EN
        // 6: odd-weight byte gives parity bit 1 and an 11-bit frame
        send_wave(8'h07, "t6");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
